// File: rtl/transconv_pkg.sv
// Shared constants and state encoding for the transposed-convolution output path.
package transconv_pkg;

    localparam int DW_DEF     = 16;
    localparam int NUM_PE_DEF = 16;
    localparam int ADDR_W_DEF = 10;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = IDLE,
        ST_COLLECT = COLLECT,
        ST_DONE    = DONE
    } state_t;

endpackage

// File: rtl/lowest_set_index.sv
// Priority encoder: index of the lowest set bit of a vector, plus a found flag.
module lowest_set_index #(
    parameter int N     = 16,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    // Scan downwards so the lowest set bit is the last one to win.
    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

    assign o_found = |i_vec;

endmodule

// File: rtl/transconv_output_collector.sv
// Captures final PE partial sums on en_output strobes and writes them to the
// output BRAM one per cycle in ascending PE order, then pulses done.
module transconv_output_collector
    import transconv_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int NUM_PE = NUM_PE_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [NUM_PE-1:0]    en_output,
    input  logic [NUM_PE*DW-1:0] pe_psum,
    output logic                 bram_we,
    output logic [ADDR_W-1:0]    bram_addr,
    output logic [DW-1:0]        bram_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);

    localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_base;
    logic [NUM_PE-1:0]   r_valid;
    logic [NUM_PE-1:0]   r_written;
    logic [DW-1:0]       r_cap [NUM_PE];
    logic                r_bram_we;
    logic [ADDR_W-1:0]   r_bram_addr;
    logic [DW-1:0]       r_bram_wdata;
    logic                r_overflow;

    logic                w_arm;
    logic                w_collect;
    logic [IDX_W-1:0]    w_drain_idx;
    logic                w_drain_found;
    logic [NUM_PE-1:0]   w_drain_oh;
    logic [NUM_PE-1:0]   w_cap_load;
    logic [NUM_PE-1:0]   w_hit;

    assign w_arm     = (r_state == ST_IDLE) && start;
    assign w_collect = (r_state == ST_COLLECT);

    lowest_set_index #(
        .N     (NUM_PE),
        .IDX_W (IDX_W)
    ) u_drain_sel (
        .i_vec   (r_valid),
        .o_idx   (w_drain_idx),
        .o_found (w_drain_found)
    );

    assign w_drain_oh = (w_collect && w_drain_found) ? (NUM_PE'(1) << w_drain_idx) : '0;

    // A slot still holding data, even if drained this edge, or already written
    // rejects a strobe: draining sets written, so the strobe would be a repeat.
    generate
        for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_slot
            assign w_cap_load[gi] = w_collect && en_output[gi] && !r_valid[gi] && !r_written[gi];
            assign w_hit[gi]      = w_collect && en_output[gi] && (r_valid[gi] || r_written[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:    if (start) w_state_next = ST_COLLECT;
            ST_COLLECT: if (&r_written) w_state_next = ST_DONE;
            ST_DONE:    w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base     <= '0;
            r_valid    <= '0;
            r_written  <= '0;
            r_overflow <= 1'b0;
        end else if (w_arm) begin
            r_base     <= base_addr;
            r_valid    <= '0;
            r_written  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_valid    <= (r_valid & ~w_drain_oh) | w_cap_load;
            r_written  <= r_written | w_drain_oh;
            r_overflow <= r_overflow | (|w_hit);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PE; i++) begin
                r_cap[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PE; i++) begin
                if (w_cap_load[i]) begin
                    r_cap[i] <= pe_psum[i*DW +: DW];
                end
            end
        end
    end

    // Address and data hold their last values whenever no write is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bram_we    <= 1'b0;
            r_bram_addr  <= '0;
            r_bram_wdata <= '0;
        end else if (w_collect && w_drain_found) begin
            r_bram_we    <= 1'b1;
            r_bram_addr  <= r_base + ADDR_W'(w_drain_idx);
            r_bram_wdata <= r_cap[w_drain_idx];
        end else begin
            r_bram_we    <= 1'b0;
        end
    end

    assign bram_we    = r_bram_we;
    assign bram_addr  = r_bram_addr;
    assign bram_wdata = r_bram_wdata;
    assign busy       = (r_state == ST_COLLECT);
    assign done       = (r_state == ST_DONE);
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_transconv_output_collector.sv
// Scoreboard bench: stimulus queues expected BRAM writes, a negedge monitor checks them.
module tb_transconv_output_collector;

    localparam int DW     = 16;
    localparam int NUM_PE = 16;
    localparam int ADDR_W = 10;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [ADDR_W-1:0]    base_addr;
    logic [NUM_PE-1:0]    en_output;
    logic [NUM_PE*DW-1:0] pe_psum;
    logic                 bram_we;
    logic [ADDR_W-1:0]    bram_addr;
    logic [DW-1:0]        bram_wdata;
    logic                 busy;
    logic                 done;
    logic                 overflow;

    always #5 clk = ~clk;

    transconv_output_collector #(
        .DW     (DW),
        .NUM_PE (NUM_PE),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .en_output  (en_output),
        .pe_psum    (pe_psum),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DW-1:0]     data;
    } wr_t;

    wr_t         exp_q[$];
    int          we_cycles[$];
    int          done_cycles[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [ADDR_W-1:0] cur_base;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every presented write is popped from the scoreboard and compared.
    always @(negedge clk) begin
        wr_t e;
        if (bram_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", bram_addr, bram_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(bram_addr), 32'(e.addr));
                chk("wr_data", 32'(bram_wdata), 32'(e.data));
                $display("write addr=0x%03h data=0x%04h cycle=%0d", bram_addr, bram_wdata, cyc);
            end
            we_cycles.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cycles.push_back(cyc);
            chk("done_after_last_we", 32'(cyc), 32'(we_cycles[we_cycles.size()-1] + 1));
            chk("busy_low_at_done", 32'(busy), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pass(input logic [ADDR_W-1:0] b);
        base_addr = b;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        cur_base  = b;
    endtask

    task automatic strobe_one(input int i, input logic [DW-1:0] d, input bit expect_write);
        wr_t e;
        en_output = NUM_PE'(1) << i;
        pe_psum   = '0;
        pe_psum[i*DW +: DW] = d;
        if (expect_write) begin
            e.addr = cur_base + ADDR_W'(i);
            e.data = d;
            exp_q.push_back(e);
        end
        tick();
        en_output = '0;
    endtask

    task automatic strobe_all(input logic [DW-1:0] tag);
        wr_t e;
        en_output = '1;
        for (int i = 0; i < NUM_PE; i++) begin
            pe_psum[i*DW +: DW] = tag | DW'(i * 16'h0111);
            e.addr = cur_base + ADDR_W'(i);
            e.data = tag | DW'(i * 16'h0111);
            exp_q.push_back(e);
        end
        tick();
        en_output = '0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cycles.size();
        int k  = 0;
        while (done_cycles.size() == d0 && k < budget) begin
            tick();
            k++;
        end
        if (done_cycles.size() == d0) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: got no done after %0d cycles expected a done pulse", budget);
        end
    endtask

    task automatic finish_pass(input int w0, input int d0);
        repeat (3) tick();
        chk("pass_write_count", 32'(we_cycles.size() - w0), 32'd16);
        chk("pass_done_count", 32'(done_cycles.size() - d0), 32'd1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_values();
        chk("rst_bram_we", 32'(bram_we), 32'd0);
        chk("rst_bram_addr", 32'(bram_addr), 32'd0);
        chk("rst_bram_wdata", 32'(bram_wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
    endtask

    initial begin
        int w0, d0, s;
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        en_output = '0;
        pe_psum   = '0;
        cur_base  = '0;
        repeat (2) tick();
        check_reset_values();
        rst_n = 1'b1;
        tick();

        // Staggered strobes, psum = i*0x0101 at 0x100.
        w0 = we_cycles.size(); d0 = done_cycles.size();
        start_pass(10'h100);
        chk("busy_collect", 32'(busy), 32'd1);
        s = cyc;
        for (int i = 0; i < NUM_PE; i++) strobe_one(i, DW'(i * 16'h0101), 1'b1);
        wait_done(64);
        if (we_cycles.size() > w0) chk("stagger_first_latency", 32'(we_cycles[w0] - s), 32'd2);
        finish_pass(w0, d0);
        chk("stagger_overflow", 32'(overflow), 32'd0);

        // All sixteen strobes in one cycle: 16 back-to-back writes.
        w0 = we_cycles.size(); d0 = done_cycles.size();
        start_pass(10'h040);
        s = cyc;
        strobe_all(16'hC000);
        wait_done(64);
        if (we_cycles.size() >= w0 + 16) begin
            chk("burst_first_latency", 32'(we_cycles[w0] - s), 32'd2);
            chk("burst_span", 32'(we_cycles[w0+15] - we_cycles[w0]), 32'd15);
        end
        finish_pass(w0, d0);

        // Address wrap: 0x3FA..0x3FF then 0x000..0x009.
        w0 = we_cycles.size(); d0 = done_cycles.size();
        start_pass(10'h3FA);
        strobe_all(16'hA000);
        wait_done(64);
        finish_pass(w0, d0);

        // Duplicate strobe of PE5 after its write raises sticky overflow.
        w0 = we_cycles.size(); d0 = done_cycles.size();
        start_pass(10'h180);
        for (int i = 0; i < NUM_PE; i++) strobe_one(i, DW'(16'h5000 + i), 1'b1);
        strobe_one(5, 16'hDEAD, 1'b0);
        wait_done(64);
        finish_pass(w0, d0);
        chk("dup_overflow_set", 32'(overflow), 32'd1);

        // Strobes while IDLE are ignored; start mid-pass is ignored.
        w0 = we_cycles.size();
        en_output = '1;
        for (int i = 0; i < NUM_PE; i++) pe_psum[i*DW +: DW] = 16'hBAD0;
        repeat (3) tick();
        en_output = '0;
        repeat (3) tick();
        chk("idle_no_writes", 32'(we_cycles.size() - w0), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        d0 = done_cycles.size();
        start_pass(10'h300);
        chk("start_clears_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) strobe_one(i, DW'(16'h3300 + i), 1'b1);
        start     = 1'b1;
        base_addr = 10'h0AA;
        strobe_one(8, 16'h3308, 1'b1);
        start     = 1'b0;
        chk("busy_after_mid_start", 32'(busy), 32'd1);
        for (int i = 9; i < NUM_PE; i++) strobe_one(i, DW'(16'h3300 + i), 1'b1);
        wait_done(64);
        finish_pass(w0, d0);

        // Reset after seven writes: abandoned pass, no done.
        w0 = we_cycles.size();
        start_pass(10'h200);
        strobe_all(16'h7000);
        for (int k = 0; k < 40 && (we_cycles.size() - w0) < 7; k++) tick();
        chk("writes_before_reset", 32'(we_cycles.size() - w0), 32'd7);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        exp_q.delete();
        d0 = done_cycles.size();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("no_done_after_reset", 32'(done_cycles.size() - d0), 32'd0);
        w0 = we_cycles.size();
        chk("no_write_after_reset", 32'(we_cycles.size() - w0 + 0), 32'd0);
        start_pass(10'h200);
        strobe_all(16'h7000);
        wait_done(64);
        finish_pass(w0, d0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected completion before 200000");
        $fatal(1, "timeout");
    end

endmodule
